multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencing controller for the RV32I core. It owns the PC and the instruction register, and fetches through a req/gnt/rvalid instruction port. It presents the latched instruction to the decoder, then steps the datapath through execute, memory and writeback using the decoder's format and opcode outputs. Illegal or unsupported instructions and misaligned control-flow targets halt the core in a sticky trap state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous active-high reset
imem_req_o  output  1  instruction fetch request
imem_addr_o  output  32  fetch address, equal to pc_o
imem_gnt_i  input  1  fetch request accepted
imem_rvalid_i  input  1  fetch data valid
imem_rdata_i  input  32  fetch data
inst_o  output  32  instruction register; drives decoder inst_i
format_i  input  inst_format_e  decoder format_o
opcode_i  input  7  decoder opcode_o
dmem_req_o  output  1  data request; address and data come from the datapath
dmem_we_o  output  1  1 = store, 0 = load; valid while dmem_req_o = 1
dmem_gnt_i  input  1  data request accepted
dmem_rvalid_i  input  1  data response valid (loads and stores)
target_i  input  32  ALU-computed jump/branch target, valid in EXECUTE
branch_taken_i  input  1  branch comparison result, valid in EXECUTE
pc_o  output  32  current PC
rf_we_o  output  1  register-file write enable, a one-cycle pulse
state_o  output  3  current state encoding, for debug
illegal_o  output  1  sticky trap flag
retired_o  output  64  retired-instruction count (optional feature)

Behaviour:
- Reset values: state FETCH, pc_o = RESET_PC, inst_o = 0, illegal_o = 0, retired_o = 0, and all strobes 0. Reset has priority over every other event, including mid-transaction. The memories share rst_i, so no stale response follows reset.
- State encodings: FETCH=0, WAIT_I=1, DECODE=2, EXECUTE=3, MEM=4, WAIT_D=5, WB=6, TRAP=7.
- FETCH: imem_req_o = 1 and imem_addr_o = pc_o, both held stable until imem_gnt_i. On gnt, go to WAIT_I.
- WAIT_I: on imem_rvalid_i, inst_o <= imem_rdata_i and go to DECODE. rvalid is sampled in WAIT_I only; it is ignored in every other state.
- DECODE: if format_i == INVALID_TYPE, go to TRAP (this covers SYSTEM, FENCE and undefined opcodes). Otherwise go to EXECUTE.
- EXECUTE: latch the next PC into an internal register.
  - JAL (1101111): next = target_i.
  - JALR (1100111): next = {target_i[31:1], 1'b0}.
  - B_TYPE with branch_taken_i = 1: next = target_i.
  - All other cases: next = pc_o + 4, mod 2^32 (0xFFFF_FFFC wraps to 0).
  - If a computed next has bit 1 set, go to TRAP.
  - Else load (0000011) or store (0100011) go to MEM; everything else goes to WB.
- MEM: dmem_req_o = 1, with dmem_we_o = 1 for a store. Both are held until dmem_gnt_i, then go to WAIT_D.
- WAIT_D: wait for dmem_rvalid_i, then go to WB.
- WB: single cycle.
  - rf_we_o = 1 for formats R, I (including loads and JALR), U and J; rf_we_o = 0 for S and B.
  - pc_o <= next; go to FETCH.
- TRAP: absorbing until reset. illegal_o = 1; pc_o and inst_o are frozen on the faulting instruction; every req/we output is 0.
- Latency with gnt in the request cycle and rvalid the cycle after:
  - Non-memory instruction: 5 cycles, FETCH to FETCH.
  - Load or store: 7 cycles.
- Each additional gnt or rvalid wait cycle adds exactly one cycle.
- Simultaneous gnt and rvalid in the same cycle is not a legal input; rvalid earliest arrives one cycle after gnt.

Optional Feature:
MULTICYCLE_CTRL_RETIRE_CNT_EN
- Defined: retired_o is a 64-bit counter that increments by 1 in each WB cycle and wraps at 2^64. Trapped instructions are not counted.
- Undefined: no counter register is built and retired_o is tied to 0.

Test Plan:
- Reset, then fetch 0x00500093 (ADDI) with gnt immediate and rvalid +1.
  - inst_o = 0x00500093 in DECODE.
  - rf_we_o pulses exactly once, in cycle 5.
  - pc_o goes 0 -> 4; imem_req_o is high again in cycle 6.
- Hold imem_gnt_i low for 3 cycles.
  - imem_req_o stays high for 4 cycles with imem_addr_o stable.
  - Total instruction latency is 8 cycles.
- BEQ 0x00000063 with branch_taken_i = 1, target_i = 0x100.
  - pc_o becomes 0x100 and rf_we_o stays 0.
- Repeat with branch_taken_i = 0.
  - pc_o becomes 4.
- JAL with target_i = 0x102.
  - Enters TRAP: illegal_o = 1, pc_o unchanged, no further imem_req_o.
- LW 0x00002083 with dmem_gnt_i delayed 2 cycles and rvalid +1.
  - dmem_req_o is high for 3 cycles with dmem_we_o = 0.
  - rf_we_o pulses in the cycle after rvalid.
- SW: dmem_we_o = 1 and rf_we_o = 0.
- 0x00000073 (ECALL): TRAP after DECODE.
- Assert rst_i during WAIT_D: state returns to FETCH, pc_o = RESET_PC and illegal_o = 0.
- With the macro defined:
  - retired_o = 3 after three instructions complete.
  - retired_o is unchanged by a trapped instruction.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH..WB sequencer for the RV32I core: owns PC and IR.
// Optional retire counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN.
package multicycle_ctrl_pkg;
  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    INVALID_TYPE
  } inst_format_e;
endpackage

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  inst_o,
  input  inst_format_e format_i,
  input  logic [6:0]   opcode_i,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  input  logic         dmem_gnt_i,
  input  logic         dmem_rvalid_i,
  input  logic [31:0]  target_i,
  input  logic         branch_taken_i,
  output logic [31:0]  pc_o,
  output logic         rf_we_o,
  output logic [2:0]   state_o,
  output logic         illegal_o,
  output logic [63:0]  retired_o
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    WAIT_I  = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WAIT_D  = 3'd5,
    WB      = 3'd6,
    TRAP    = 3'd7
  } state_e;

  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] npc_q;
  logic        illegal_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        rf_we_q;

  logic        is_jal;
  logic        is_jalr;
  logic        is_bt;
  logic        is_mem;
  logic        is_store;
  logic        wb_we;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign is_jal   = (opcode_i == OP_JAL);
  assign is_jalr  = (opcode_i == OP_JALR);
  assign is_bt    = (format_i == B_TYPE) && branch_taken_i
                    && !is_jal && !is_jalr;
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = (opcode_i == OP_LOAD) || is_store;
  assign pc_plus4 = pc_q + 32'd4;

  assign wb_we = (format_i == R_TYPE) || (format_i == I_TYPE) ||
                 (format_i == U_TYPE) || (format_i == J_TYPE);

  always_comb begin
    next_pc = pc_plus4;
    unique case (1'b1)
      is_jal:  next_pc = target_i;
      is_jalr: next_pc = {target_i[31:1], 1'b0};
      is_bt:   next_pc = target_i;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      npc_q      <= RESET_PC;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      unique case (state_q)
        FETCH: if (imem_gnt_i) begin
          imem_req_q <= 1'b0;
          state_q    <= WAIT_I;
        end
        WAIT_I: if (imem_rvalid_i) begin
          inst_q  <= imem_rdata_i;
          state_q <= DECODE;
        end
        DECODE: begin
          if (format_i == INVALID_TYPE) begin
            illegal_q <= 1'b1;
            state_q   <= TRAP;
          end else begin
            state_q <= EXECUTE;
          end
        end
        EXECUTE: begin
          npc_q <= next_pc;
          if (next_pc[1]) begin
            illegal_q <= 1'b1;
            state_q   <= TRAP;
          end else if (is_mem) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store;
            state_q    <= MEM;
          end else begin
            rf_we_q <= wb_we;
            state_q <= WB;
          end
        end
        MEM: if (dmem_gnt_i) begin
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          state_q    <= WAIT_D;
        end
        WAIT_D: if (dmem_rvalid_i) begin
          rf_we_q <= wb_we;
          state_q <= WB;
        end
        WB: begin
          pc_q       <= npc_q;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        TRAP: state_q <= TRAP;
      endcase
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = pc_q;
  assign inst_o      = inst_q;
  assign dmem_req_o  = dmem_req_q;
  assign dmem_we_o   = dmem_we_q;
  assign pc_o        = pc_q;
  assign rf_we_o     = rf_we_q;
  assign state_o     = state_q;
  assign illegal_o   = illegal_q;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [63:0] retired_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (state_q == WB) begin
      retired_q <= retired_q + 64'd1;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

endmodule
